// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the fetch stage, the memory stage, the arbiter and the
// word-wide RAM port. The arbiter takes the slave view; requesters and RAM take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic                f_req;
  logic [63:0]         f_addr;
  logic                f_done;
  logic [79:0]         f_data;

  logic                d_req;
  logic                d_we;
  logic [63:0]         d_addr;
  logic [63:0]         d_wdata;
  logic                d_done;
  logic [63:0]         d_rdata;

  logic                m_en;
  logic                m_we;
  logic [ADDR_W-4:0]   m_addr;
  logic [7:0]          m_be;
  logic [63:0]         m_wdata;
  logic [63:0]         m_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output f_done, f_data, d_done, d_rdata, m_en, m_we, m_addr, m_be, m_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  f_done, f_data, d_done, d_rdata, m_en, m_we, m_addr, m_be, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory sequencer: arbitrates fetch and data requests, splits each byte-addressed
// access into 64-bit word beats with byte enables, and reassembles unaligned read data.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);
  localparam int WW = ADDR_W - 3;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

  function automatic logic [63:0] asm_data(input logic [127:0] v, input logic [2:0] o);
    return 64'(v >> {o, 3'b000});
  endfunction

  function automatic logic [79:0] asm_fetch(input logic [191:0] v, input logic [2:0] o);
    return 80'(v >> {o, 3'b000});
  endfunction

  function automatic logic [7:0] write_be(input logic first, input logic [2:0] o);
    return first ? (8'hFF << o) : (8'hFF >> (4'd8 - {1'b0, o}));
  endfunction

  function automatic logic [63:0] write_data(input logic first, input logic [63:0] d,
                                             input logic [2:0] o);
    return first ? (d << {o, 3'b000}) : (d >> (7'd64 - {1'b0, o, 3'b000}));
  endfunction

  state_e          state_q, state_d;
  logic            is_f_q, is_f_d;
  logic            we_q, we_d;
  logic [2:0]      off_q, off_d;
  logic [1:0]      nb_q, nb_d;
  logic [1:0]      beat_q, beat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [79:0]     f_data_q, f_data_d;
  logic [63:0]     d_rdata_q, d_rdata_d;
  logic [WW-1:0]   word_q, word_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [63:0]     b0_q, b0_d, b1_q, b1_d;

  logic            grant_f, grant_d;
  logic [63:0]     a0, a1, a2;
  logic            m_en, m_we;
  logic [WW-1:0]   m_addr;
  logic [7:0]      m_be;
  logic [63:0]     m_wdata;

  // Address bits above ADDR_W do not select memory.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^{bus.f_addr[63:ADDR_W], bus.d_addr[63:ADDR_W]};

  always_comb begin
    state_d   = state_q;
    is_f_d    = is_f_q;
    we_d      = we_q;
    off_d     = off_q;
    nb_d      = nb_q;
    beat_d    = beat_q;
    starve_d  = starve_q;
    f_data_d  = f_data_q;
    d_rdata_d = d_rdata_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    a0        = b0_q;
    a1        = b1_q;
    a2        = '0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_be      = '0;
    m_wdata   = '0;

    case (state_q)
      IDLE: begin
        // Data normally wins; a fetch that has waited STARVE_MAX data grants goes first.
        grant_f = bus.f_req && (!bus.d_req || starve_q == STARVE_LIM);
        grant_d = bus.d_req && !grant_f;
        if (grant_f) begin
          is_f_d   = 1'b1;
          we_d     = 1'b0;
          off_d    = bus.f_addr[2:0];
          word_d   = bus.f_addr[ADDR_W-1:3];
          nb_d     = (bus.f_addr[2:0] == 3'd7) ? 2'd3 : 2'd2;
          beat_d   = 2'd0;
          starve_d = '0;
          state_d  = ISSUE;
        end else if (grant_d) begin
          is_f_d   = 1'b0;
          we_d     = bus.d_we;
          off_d    = bus.d_addr[2:0];
          word_d   = bus.d_addr[ADDR_W-1:3];
          wdata_d  = bus.d_wdata;
          nb_d     = (bus.d_addr[2:0] == 3'd0) ? 2'd1 : 2'd2;
          beat_d   = 2'd0;
          if (bus.f_req)
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
          else
            starve_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        m_en   = 1'b1;
        m_we   = we_q;
        m_addr = word_q + WW'(beat_q);
        if (we_q) begin
          m_be    = write_be(beat_q == 2'd0, off_q);
          m_wdata = write_data(beat_q == 2'd0, wdata_q, off_q);
        end else begin
          m_be = 8'hFF;
          // RAM returns the previous beat's word this cycle.
          case (beat_q)
            2'd1:    b0_d = bus.m_rdata;
            2'd2:    b1_d = bus.m_rdata;
            default: ;
          endcase
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == nb_q - 2'd1)
          state_d = we_q ? RESP : DRAIN;
      end
      DRAIN: begin
        // Last beat is taken straight from the RAM so the result register is ready in RESP.
        case (nb_q)
          2'd1:    a0 = bus.m_rdata;
          2'd2:    a1 = bus.m_rdata;
          default: a2 = bus.m_rdata;
        endcase
        if (is_f_q)
          f_data_d = asm_fetch({a2, a1, a0}, off_q);
        else
          d_rdata_d = asm_data({a1, a0}, off_q);
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      is_f_q    <= 1'b0;
      we_q      <= 1'b0;
      off_q     <= '0;
      nb_q      <= '0;
      beat_q    <= '0;
      starve_q  <= '0;
      f_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      is_f_q    <= is_f_d;
      we_q      <= we_d;
      off_q     <= off_d;
      nb_q      <= nb_d;
      beat_q    <= beat_d;
      starve_q  <= starve_d;
      f_data_q  <= f_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    word_q  <= word_d;
    wdata_q <= wdata_d;
    b0_q    <= b0_d;
    b1_q    <= b1_d;
  end

  assign bus.m_en    = m_en;
  assign bus.m_we    = m_we;
  assign bus.m_addr  = m_addr;
  assign bus.m_be    = m_be;
  assign bus.m_wdata = m_wdata;
  assign bus.f_done  = (state_q == RESP) && is_f_q;
  assign bus.d_done  = (state_q == RESP) && !is_f_q;
  assign bus.f_data  = f_data_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table through a scoreboard, plus starvation and
// mid-transaction reset sequences, against a behavioural word-wide RAM.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int WW     = ADDR_W - 3;

  typedef struct {
    bit          is_f;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [79:0] exp;
    int          lat;
    int          nb;
    logic [12:0] w0;
    logic [7:0]  be0;
    logic [7:0]  be1;
  } vec_t;

  typedef struct {
    logic [79:0] data;
    int          lat;
  } sb_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // RAM: byte at address a initially holds a[7:0]; read data valid the cycle after the beat.
  logic [63:0] ram [0:(1<<WW)-1];
  logic [63:0] rd_q;
  bit          ram_ready = 1'b0;
  assign bus.m_rdata = rd_q;

  always @(posedge clock) begin
    if (!ram_ready) begin
      for (int w = 0; w < (1 << WW); w++)
        for (int k = 0; k < 8; k++)
          ram[w][8*k +: 8] <= 8'(w * 8 + k);
      ram_ready <= 1'b1;
      rd_q      <= '0;
    end else if (bus.m_en) begin
      if (bus.m_we) begin
        for (int k = 0; k < 8; k++)
          if (bus.m_be[k]) ram[bus.m_addr][8*k +: 8] <= bus.m_wdata[8*k +: 8];
      end else begin
        rd_q <= ram[bus.m_addr];
      end
    end
  end

  logic [21:0] bq[$];
  int          idle_bad = 0;
  always @(negedge clock) begin
    if (bus.m_en)
      bq.push_back({bus.m_we, bus.m_addr, bus.m_be});
    else if (bus.m_we || bus.m_addr != '0 || bus.m_be != '0 || bus.m_wdata != '0)
      idle_bad <= idle_bad + 1;
  end

  int          npass = 0;
  int          ntot  = 0;
  sb_t         sbq[$];
  logic [63:0] last_d;
  logic [79:0] last_f;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // Called #1 after a rising edge with the arbiter idle; returns at the same phase, req dropped.
  task automatic run_vec(input vec_t v, input string nm);
    sb_t         s;
    int          lat;
    bit          got;
    logic [7:0]  be;
    logic [79:0] data;
    bq.delete();
    if (v.is_f) begin
      bus.f_req  = 1'b1;
      bus.f_addr = v.addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end
    sbq.push_back('{v.exp, v.lat});
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      got = v.is_f ? bus.f_done : bus.d_done;
    end
    check({nm, ".done_seen"}, 80'(got), 80'(1));
    s = sbq.pop_front();
    check({nm, ".latency"}, 80'(lat), 80'(s.lat));
    if (v.is_f || !v.we) begin
      data = v.is_f ? bus.f_data : {16'h0, bus.d_rdata};
      check({nm, ".data"}, data, s.data);
    end
    if (!v.is_f && !v.we) begin
      check({nm, ".f_data_hold"}, bus.f_data, last_f);
      last_d = s.data[63:0];
    end else begin
      check({nm, ".d_rdata_hold"}, {16'h0, bus.d_rdata}, {16'h0, last_d});
      if (v.is_f) last_f = s.data;
    end
    check({nm, ".nbeats"}, 80'(bq.size()), 80'(v.nb));
    for (int k = 0; k < bq.size() && k < v.nb; k++) begin
      be = (k == 0) ? v.be0 : (k == 1) ? v.be1 : 8'hFF;
      check($sformatf("%s.beat%0d", nm, k), 80'(bq[k]), 80'({v.we, 13'(v.w0 + 13'(k)), be}));
    end
    @(posedge clock); #1;
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  initial begin
    vec_t        tbl[13];
    vec_t        pv;
    int          n;
    int          cyc;
    int          dn;
    logic [9:0]  order;

    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    reset_n     = 1'b0;
    last_d      = '0;
    last_f      = '0;

    //         is_f we addr                   wdata                  exp                          lat nb w0       be0    be1
    tbl[0]  = '{1'b0, 1'b1, 64'h100,             64'h1122334455667788, 80'h0,                        2, 1, 13'h020, 8'hFF, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 64'h100,             64'h0,                80'h1122334455667788,         3, 1, 13'h020, 8'hFF, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 64'h103,             64'hA1B2C3D4E5F60718, 80'h0,                        3, 2, 13'h020, 8'hF8, 8'h07};
    tbl[3]  = '{1'b0, 1'b0, 64'h103,             64'h0,                80'hA1B2C3D4E5F60718,         4, 2, 13'h020, 8'hFF, 8'hFF};
    tbl[4]  = '{1'b0, 1'b0, 64'h100,             64'h0,                80'hD4E5F60718667788,         3, 1, 13'h020, 8'hFF, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 64'h7,               64'h0,                80'h100F0E0D0C0B0A090807,     5, 3, 13'h000, 8'hFF, 8'hFF};
    tbl[6]  = '{1'b1, 1'b0, 64'h6,               64'h0,                80'h0F0E0D0C0B0A09080706,     4, 2, 13'h000, 8'hFF, 8'hFF};
    tbl[7]  = '{1'b0, 1'b0, 64'hFFFD,            64'h0,                80'h0403020100FFFEFD,         4, 2, 13'h1FFF, 8'hFF, 8'hFF};
    tbl[8]  = '{1'b0, 1'b1, 64'hFFFE,            64'h0123456789ABCDEF, 80'h0,                        3, 2, 13'h1FFF, 8'hC0, 8'h3F};
    tbl[9]  = '{1'b0, 1'b0, 64'hFFFE,            64'h0,                80'h0123456789ABCDEF,         4, 2, 13'h1FFF, 8'hFF, 8'hFF};
    tbl[10] = '{1'b1, 1'b0, 64'hFFFA,            64'h0,                80'h456789ABCDEFFDFCFBFA,     4, 2, 13'h1FFF, 8'hFF, 8'hFF};
    tbl[11] = '{1'b1, 1'b0, 64'h1000,            64'h0,                80'h09080706050403020100,     4, 2, 13'h200, 8'hFF, 8'hFF};
    tbl[12] = '{1'b0, 1'b0, 64'hABCD000000000238, 64'h0,               80'h3F3E3D3C3B3A3938,         3, 1, 13'h047, 8'hFF, 8'h00};

    repeat (3) @(posedge clock);
    #1;
    check("rst.f_done",  80'(bus.f_done),  80'(0));
    check("rst.d_done",  80'(bus.d_done),  80'(0));
    check("rst.m_en",    80'(bus.m_en),    80'(0));
    check("rst.f_data",  bus.f_data,       80'(0));
    check("rst.d_rdata", 80'(bus.d_rdata), 80'(0));
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 13; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // Both requesters held continuously: four data grants, then the starved fetch.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h100;
    bus.f_req  = 1'b1;
    bus.f_addr = 64'h7;
    n     = 0;
    cyc   = 0;
    order = '0;
    while (n < 10 && cyc < 400) begin
      @(posedge clock); #1;
      cyc++;
      if (bus.d_done) begin
        check("starve.d_rdata", {16'h0, bus.d_rdata}, 80'h0000D4E5F60718667788);
        n++;
      end else if (bus.f_done) begin
        check("starve.f_data", bus.f_data, 80'h100F0E0D0C0B0A090807);
        order[n] = 1'b1;
        n++;
      end
    end
    check("starve.count", 80'(n), 80'(10));
    check("starve.order", 80'(order), 80'(10'b1000010000));
    @(posedge clock); #1;
    bus.d_req = 1'b0;
    bus.f_req = 1'b0;
    @(posedge clock); #1;

    // Reset lands in the first ISSUE cycle of an unaligned write.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'h203;
    bus.d_wdata = 64'h5A5A5A5A5A5A5A5A;
    @(posedge clock); #1;
    check("rstmid.m_en_before", 80'(bus.m_en), 80'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rstmid.m_en",    80'(bus.m_en),    80'(0));
    check("rstmid.m_we",    80'(bus.m_we),    80'(0));
    check("rstmid.d_done",  80'(bus.d_done),  80'(0));
    check("rstmid.d_rdata", 80'(bus.d_rdata), 80'(0));
    check("rstmid.f_data",  bus.f_data,       80'(0));
    bus.d_req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    dn = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (bus.d_done || bus.f_done) dn++;
    end
    check("rstmid.no_done", 80'(dn), 80'(0));
    last_d = '0;
    last_f = '0;
    pv = '{1'b0, 1'b0, 64'h103, 64'h0, 80'hA1B2C3D4E5F60718, 4, 2, 13'h020, 8'hFF, 8'hFF};
    run_vec(pv, "post_rst");

    check("bus_idle_zero", 80'(idle_bad), 80'(0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory sequencer shared by the instruction-fetch stage and the memory stage of the Y86-64 core. Accepts a 10-byte instruction fetch request and an 8-byte data read/write request at arbitrary byte addresses, arbitrates between them, and splits each access into 64-bit word beats with byte enables on one synchronous word-wide RAM port. Unaligned accesses are reassembled, so requesters see byte-addressed little-endian data.

## Interface
- ADDR_W, 16, byte-address bits used; word index is ADDR_W-3 bits
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request; held with f_addr stable until f_done
- f_addr  in  64  fetch byte address (PC)
- f_done  out  1  one-cycle pulse: f_data valid
- f_data  out  80  fetched bytes f_addr..f_addr+9, byte 0 in [7:0]
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  64  data byte address
- d_wdata  in  64  write data, little-endian
- d_done  out  1  one-cycle pulse: access complete, d_rdata valid for reads
- d_rdata  out  64  read data
- m_en  out  1  RAM beat valid
- m_we  out  1  RAM write
- m_addr  out  ADDR_W-3  RAM word index
- m_be  out  8  byte enables (8'hFF on reads)
- m_wdata  out  64  RAM write data
- m_rdata  in  64  RAM read data, valid the cycle after a read beat

## Operation
- Only address bits [ADDR_W-1:0] used; o = addr[2:0], w = addr[ADDR_W-1:3]. Beat k targets word (w+k) mod 2^(ADDR_W-3) (wrap at top of memory).
- Beat counts: data N = 1 if o==0 else 2; fetch N = 2 if o<=6, 3 if o==7.
- Data write: beat 0 be = 8'hFF<<o, wdata = d_wdata<<8o; beat 1 be = 8'hFF>>(8-o), wdata = d_wdata>>(64-8o). Bytes outside be untouched.
- Reads: beat k data captured into assembly buffer slot k. d_rdata = ({b1,b0}>>8o)[63:0]; f_data = ({b2,b1,b0}>>8o)[79:0].
- FSM: IDLE -> ISSUE (N cycles, m_en=1, one beat per cycle) -> DRAIN (reads only, captures last beat) -> RESP (done pulse, output register updated) -> IDLE.
- Arbitration in IDLE only: data wins over fetch, except when both request and starve count == STARVE_MAX, then fetch wins. Starve count increments on a data grant with f_req high, clears on a fetch grant or a data grant with f_req low; saturates at STARVE_MAX.
- Operands latched at grant; requester changes after grant are ignored until done.
- f_data/d_rdata registered; hold value until that port's next done. Writes leave d_rdata unchanged.

## Timing
- Cycle 0 = IDLE cycle sampling req high. ISSUE cycles 1..N. Read: DRAIN N+1, done N+2. Write: done N+1.
- Latencies (req sample to done): data write aligned 2, unaligned 3; data read aligned 3, unaligned 4; fetch o<=6 4, o==7 5.
- Requester drops req (or presents a new request) in the cycle after done; IDLE after RESP samples it. Minimum gap between transactions: 1 IDLE cycle.
- m_en/m_we/m_addr/m_be/m_wdata are 0 outside ISSUE; m_we=1 only in ISSUE of a write.
- Reset (async, any state): FSM to IDLE, starve count 0, all outputs 0 immediately; in-flight transaction dropped without done; beats already written stay written.

## Test plan
- Aligned write d_addr=0x100, d_wdata=0x1122334455667788, then read 0x100 -> one beat be=8'hFF word 0x20; done cycle 2; read d_rdata=0x1122334455667788 at cycle 3.
- Unaligned write d_addr=0x103 -> beats word 0x20 be=8'hF8, word 0x21 be=8'h07; read 0x103 returns same value at cycle 4; bytes 0x100-0x102 unchanged.
- Fetch f_addr=0x7 over RAM bytes i at address i -> 3 beats words 0,1,2; f_data = bytes 0x07..0x10 (0x100F0E0D0C0B0A090807); done cycle 5. f_addr=0x6 -> 2 beats, done cycle 4.
- Wrap: ADDR_W=16, d_addr=0xFFFD read -> beats word 0x1FFF then 0x0000; result assembles bytes 0xFFFD..0xFFFF,0x0000..0x0004.
- Both req continuously held, STARVE_MAX=4 -> grant order D,D,D,D,F,D...; starve count 0 after F.
- reset_n low during ISSUE of an unaligned write -> m_en=0 same cycle, no d_done, FSM IDLE; after release a new read completes normally.
